// File: rtl/bp_update_ctrl.sv
// Branch predictor update sequencer: tracks in-flight predictions in order, matches
// them to resolved outcomes, drives the predictor update port and flags mispredicts.
module bp_update_ctrl #(
   parameter int unsigned PC_WIDTH  = 32,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 br_valid,
   input  logic [PC_WIDTH-1:0]  br_pc,
   input  logic                 br_pred_taken,
   output logic                 stall_fetch,
   input  logic                 res_valid,
   input  logic                 res_taken,
   output logic                 bp_update_en,
   output logic                 bp_actual_taken,
   output logic                 mispredict,
   output logic [PC_WIDTH-1:0]  mispredict_pc,
   output logic                 underflow_err,
   output logic [CNT_WIDTH-1:0] stat_branches,
   output logic [CNT_WIDTH-1:0] stat_mispredicts
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_TRACK   = 2'd1,
      S_FULL    = 2'd2,
      S_RECOVER = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [PTR_W-1:0]     wptr_q, wptr_d;
   logic [PTR_W-1:0]     rptr_q, rptr_d;
   logic [PTR_W-1:0]     count, count_d;
   logic [PC_WIDTH-1:0]  pc_mem   [DEPTH];
   logic                 pred_mem [DEPTH];

   logic                 upd_q, upd_d;
   logic                 act_q, act_d;
   logic                 misp_q, misp_d;
   logic [PC_WIDTH-1:0]  mpc_q, mpc_d;
   logic                 uflow_q, uflow_d;
   logic [CNT_WIDTH-1:0] nbr_q, nbr_d;
   logic [CNT_WIDTH-1:0] nmis_q, nmis_d;

   logic                 push;
   logic                 resolve;
   logic                 miss;
   logic [PC_WIDTH-1:0]  head_pc;
   logic                 head_pred;

   // Occupancy is the pointer distance; a flush makes both pointers equal.
   assign count       = wptr_q - rptr_q;
   assign stall_fetch = (state_q == S_FULL) || (state_q == S_RECOVER);
   assign head_pc     = pc_mem[rptr_q[IDX_W-1:0]];
   assign head_pred   = pred_mem[rptr_q[IDX_W-1:0]];
   assign push        = br_valid && !stall_fetch;
   assign resolve     = res_valid && (count != '0);
   assign miss        = resolve && (head_pred != res_taken);

   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      upd_d   = 1'b0;
      act_d   = act_q;
      misp_d  = 1'b0;
      mpc_d   = mpc_q;
      uflow_d = uflow_q;
      nbr_d   = nbr_q;
      nmis_d  = nmis_q;

      if (res_valid && (count == '0)) begin
         uflow_d = 1'b1;
      end

      if (resolve) begin
         upd_d  = 1'b1;
         act_d  = res_taken;
         rptr_d = rptr_q + PTR_W'(1);
         if (nbr_q != '1) begin
            nbr_d = nbr_q + CNT_WIDTH'(1);
         end
      end

      if (miss) begin
         // Flush everything; a same-cycle push is wrong-path and is discarded.
         misp_d = 1'b1;
         mpc_d  = head_pc;
         wptr_d = rptr_q + PTR_W'(1);
         if (nmis_q != '1) begin
            nmis_d = nmis_q + CNT_WIDTH'(1);
         end
      end else if (push) begin
         wptr_d = wptr_q + PTR_W'(1);
      end

      count_d = wptr_d - rptr_d;

      if (miss) begin
         state_d = S_RECOVER;
      end else if (state_q == S_RECOVER) begin
         state_d = S_IDLE;
      end else if (count_d == '0) begin
         state_d = S_IDLE;
      end else if (count_d == PTR_W'(DEPTH)) begin
         state_d = S_FULL;
      end else begin
         state_d = S_TRACK;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         upd_q   <= 1'b0;
         act_q   <= 1'b0;
         misp_q  <= 1'b0;
         mpc_q   <= '0;
         uflow_q <= 1'b0;
         nbr_q   <= '0;
         nmis_q  <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         upd_q   <= upd_d;
         act_q   <= act_d;
         misp_q  <= misp_d;
         mpc_q   <= mpc_d;
         uflow_q <= uflow_d;
         nbr_q   <= nbr_d;
         nmis_q  <= nmis_d;
      end
   end

   // Entry storage needs no reset: only slots between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wptr_q[IDX_W-1:0]]   <= br_pc;
         pred_mem[wptr_q[IDX_W-1:0]] <= br_pred_taken;
      end
   end

   assign bp_update_en     = upd_q;
   assign bp_actual_taken  = act_q;
   assign mispredict       = misp_q;
   assign mispredict_pc    = mpc_q;
   assign underflow_err    = uflow_q;
   assign stat_branches    = nbr_q;
   assign stat_mispredicts = nmis_q;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Bench for bp_update_ctrl: directed scenarios plus random traffic checked against
// a queue-based model of prediction tracking and resolution.
module tb_bp_update_ctrl;

   localparam int unsigned PCW   = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNTW  = 4;
   localparam int unsigned CMAX  = (1 << CNTW) - 1;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            br_valid = 1'b0;
   logic [PCW-1:0]  br_pc = '0;
   logic            br_pred_taken = 1'b0;
   logic            stall_fetch;
   logic            res_valid = 1'b0;
   logic            res_taken = 1'b0;
   logic            bp_update_en;
   logic            bp_actual_taken;
   logic            mispredict;
   logic [PCW-1:0]  mispredict_pc;
   logic            underflow_err;
   logic [CNTW-1:0] stat_branches;
   logic [CNTW-1:0] stat_mispredicts;

   bp_update_ctrl #(.PC_WIDTH(PCW), .DEPTH(DEPTH), .CNT_WIDTH(CNTW)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .br_valid         (br_valid),
      .br_pc            (br_pc),
      .br_pred_taken    (br_pred_taken),
      .stall_fetch      (stall_fetch),
      .res_valid        (res_valid),
      .res_taken        (res_taken),
      .bp_update_en     (bp_update_en),
      .bp_actual_taken  (bp_actual_taken),
      .mispredict       (mispredict),
      .mispredict_pc    (mispredict_pc),
      .underflow_err    (underflow_err),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PCW-1:0] pc;
      logic           pred;
   } ent_t;

   ent_t           mq[$];
   logic           m_recover;
   logic           m_upd, m_act, m_misp, m_uflow;
   logic [PCW-1:0] m_mpc;
   int unsigned    m_nbr, m_nmis;

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_clear();
      mq.delete();
      m_recover = 1'b0;
      m_upd = 1'b0; m_act = 1'b0; m_misp = 1'b0; m_uflow = 1'b0;
      m_mpc = '0; m_nbr = 0; m_nmis = 0;
   endfunction

   // One clock: drive at negedge, check stall, advance the model, check registered outputs.
   task automatic step(input logic bv, input logic [PCW-1:0] pc, input logic pr,
                       input logic rv, input logic rt);
      logic m_stall;
      ent_t head;
      @(negedge clk);
      br_valid = bv; br_pc = pc; br_pred_taken = pr;
      res_valid = rv; res_taken = rt;
      m_stall = m_recover || (mq.size() == DEPTH);
      check_eq("stall_fetch", 64'(stall_fetch), 64'(m_stall));

      m_upd  = 1'b0;
      m_misp = 1'b0;
      if (m_recover) m_recover = 1'b0;
      if (rv && mq.size() != 0) begin
         head  = mq.pop_front();
         m_upd = 1'b1;
         m_act = rt;
         if (m_nbr < CMAX) m_nbr++;
         if (head.pred != rt) begin
            m_misp = 1'b1;
            m_mpc  = head.pc;
            if (m_nmis < CMAX) m_nmis++;
            mq.delete();
            m_recover = 1'b1;
         end else if (bv && !m_stall) begin
            mq.push_back('{pc, pr});
         end
      end else begin
         if (rv) m_uflow = 1'b1;
         if (bv && !m_stall) mq.push_back('{pc, pr});
      end

      @(posedge clk);
      #1;
      check_eq("bp_update_en", 64'(bp_update_en), 64'(m_upd));
      if (m_upd) check_eq("bp_actual_taken", 64'(bp_actual_taken), 64'(m_act));
      check_eq("mispredict", 64'(mispredict), 64'(m_misp));
      check_eq("mispredict_pc", 64'(mispredict_pc), 64'(m_mpc));
      check_eq("underflow_err", 64'(underflow_err), 64'(m_uflow));
      check_eq("stat_branches", 64'(stat_branches), 64'(m_nbr));
      check_eq("stat_mispredicts", 64'(stat_mispredicts), 64'(m_nmis));
   endtask

   // Assert reset in mid-cycle, verify outputs clear without a clock edge, then release.
   task automatic do_reset();
      @(negedge clk);
      br_valid = 1'b0; res_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("rst_stall", 64'(stall_fetch), 64'd0);
      check_eq("rst_upd", 64'(bp_update_en), 64'd0);
      check_eq("rst_act", 64'(bp_actual_taken), 64'd0);
      check_eq("rst_misp", 64'(mispredict), 64'd0);
      check_eq("rst_mpc", 64'(mispredict_pc), 64'd0);
      check_eq("rst_uflow", 64'(underflow_err), 64'd0);
      check_eq("rst_nbr", 64'(stat_branches), 64'd0);
      check_eq("rst_nmis", 64'(stat_mispredicts), 64'd0);
      model_clear();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      logic [PCW-1:0] pc;
      logic pr, rt, bv, rv;

      model_clear();
      #12;
      reset_n = 1'b1;

      // Reset with two entries queued, then a resolve into the empty queue.
      step(1'b1, 32'h10, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h14, 1'b0, 1'b0, 1'b0);
      do_reset();
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

      // Correct predictions, back-to-back resolves.
      do_reset();
      step(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      check_eq("two_branches", 64'(stat_branches), 64'd2);

      // Fill, drop a push while full, release, then wrap the pointers.
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 32'h300 + 32'(4 * i), 1'(i & 1), 1'b0, 1'b0);
      step(1'b1, 32'h3F0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         rt = mq.size() != 0 ? mq[0].pred : 1'b0;
         step(1'b1, 32'h400 + 32'(4 * i), 1'(i % 3 == 0), 1'b1, rt);
      end
      while (mq.size() != 0) step(1'b0, 32'h0, 1'b0, 1'b1, mq[0].pred);

      // Mispredict with a same-cycle wrong-path push, then recovery.
      do_reset();
      step(1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h204, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h208, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h20C, 1'b0, 1'b1, 1'b0);
      check_eq("flush_pc", 64'(mispredict_pc), 64'h200);
      step(1'b1, 32'h210, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

      // Push together with a correct resolve at count 2 keeps FIFO order.
      do_reset();
      step(1'b1, 32'h500, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h504, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h508, 1'b1, 1'b1, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

      // Saturation of the resolved-branch counter.
      do_reset();
      step(1'b1, 32'h600, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, 32'h604 + 32'(4 * i), 1'b1, 1'b1, 1'b1);
      check_eq("sat_branches", 64'(stat_branches), 64'(CMAX));

      // Random traffic with occasional mid-run resets.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         bv = ($urandom_range(0, 99) < 60);
         rv = ($urandom_range(0, 99) < 45);
         pc = $urandom();
         pr = 1'($urandom());
         if (mq.size() != 0) rt = ($urandom_range(0, 9) == 0) ? ~mq[0].pred : mq[0].pred;
         else rt = 1'($urandom());
         step(bv, pc, pr, rv, rt);
      end

      @(negedge clk);
      br_valid = 1'b0; res_valid = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
